// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 Hz VGA raster timing generator.
// A clock divider produces the pixel strobe, and horizontal/vertical counters
// drive hcount/vcount for the renderer. The renderer's RGB is registered
// together with the sync signals, so colour and sync stay aligned at the pins.
// Optional build macro VGA_TEST_PATTERN_EN adds a test_en input that replaces
// the renderer RGB with an internal 64-pixel colour-bar pattern.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter int   CLK_DIV  = 2,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
`ifdef VGA_TEST_PATTERN_EN
  input  logic       test_en,
`endif
  output logic       pix_en,
  output logic [9:0] hcount,
  output logic [8:0] vcount,
  output logic       active,
  output logic       frame_start,
  input  logic [7:0] red_in,
  input  logic [7:0] green_in,
  input  logic [7:0] blue_in,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

  logic [DIV_W-1:0] div;
  logic             run;
  logic [9:0]       h;
  logic [9:0]       v;
  logic             line_end;
  logic             hs_raw;
  logic             vs_raw;
  logic [7:0]       src_r;
  logic [7:0]       src_g;
  logic [7:0]       src_b;

  // Pixel divider; run keeps the strobe low until the first clk after reset,
  // which matters when CLK_DIV=1 and div sits permanently at its last value.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div <= '0;
      run <= 1'b0;
    end else begin
      run <= 1'b1;
      div <= (div == DIV_LAST) ? '0 : div + 1'b1;
    end
  end

  assign pix_en   = run && (div == DIV_LAST);
  assign line_end = (h == H_LAST);

  // Raster counters: h steps once per pixel, v steps at the end of each line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h <= '0;
      v <= '0;
    end else if (pix_en) begin
      h <= line_end ? '0 : h + 1'b1;
      if (line_end) begin
        v <= (v == V_LAST) ? '0 : v + 1'b1;
      end
    end
  end

  assign hcount      = h;
  assign vcount      = v[8:0];
  assign active      = (h < 10'(H_ACTIVE)) && (v < 10'(V_ACTIVE));
  assign frame_start = pix_en && line_end && (v == V_LAST);
  assign hs_raw      = (h >= 10'(HS_START)) && (h < 10'(HS_END));
  assign vs_raw      = (v >= 10'(VS_START)) && (v < 10'(VS_END));

  // Select the colour source for the current pixel.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    src_r = red_in;
    src_g = green_in;
    src_b = blue_in;
`ifdef VGA_TEST_PATTERN_EN
    // Only bar bits [2:0] pick a colour, so h[9] is not needed: bars 8 and 9
    // repeat the colours of bars 0 and 1.
    if (test_en) begin
      src_r = {8{h[8]}};
      src_g = {8{h[7]}};
      src_b = {8{h[6]}};
    end
`endif
  end

  // Output stage: RGB, blanking and syncs registered together on each strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vga_r   <= '0;
      vga_g   <= '0;
      vga_b   <= '0;
      blank_n <= 1'b0;
      hsync   <= ~SYNC_POL;
      vsync   <= ~SYNC_POL;
    end else if (pix_en) begin
      vga_r   <= active ? src_r : 8'h00;
      vga_g   <= active ? src_g : 8'h00;
      vga_b   <= active ? src_b : 8'h00;
      blank_n <= active;
      hsync   <= hs_raw ? SYNC_POL : ~SYNC_POL;
      vsync   <= vs_raw ? SYNC_POL : ~SYNC_POL;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen.
// dut_a uses the default 640x480 timing for reset, line timing, latency and
// horizontal blanking. dut_b keeps the default vertical timing but uses a
// 24-pixel line and CLK_DIV=1, so whole frames (vsync, frame_start, vcount
// aliasing, vertical blanking, mid-frame reset) run in a short time.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic rgb_mode;

  logic       pix_en_a, active_a, fs_a, hsync_a, vsync_a, blank_n_a;
  logic [9:0] hcount_a;
  logic [8:0] vcount_a;
  logic [7:0] red_a, green_a, blue_a, vga_r_a, vga_g_a, vga_b_a;

  logic       pix_en_b, active_b, fs_b, hsync_b, vsync_b, blank_n_b;
  logic [9:0] hcount_b;
  logic [8:0] vcount_b;
  logic [7:0] red_b, green_b, blue_b, vga_r_b, vga_g_b, vga_b_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Renderer stand-in: red follows hcount once rgb_mode is set.
  always_comb begin
    red_a   = rgb_mode ? hcount_a[7:0] : 8'hFF;
    green_a = 8'hAA;
    blue_a  = 8'h55;
    red_b   = rgb_mode ? hcount_b[7:0] : 8'hFF;
    green_b = 8'hAA;
    blue_b  = 8'h55;
  end

  vga_timing_gen dut_a (
    .clk(clk), .reset(rst_a), .pix_en(pix_en_a), .hcount(hcount_a),
    .vcount(vcount_a), .active(active_a), .frame_start(fs_a),
    .red_in(red_a), .green_in(green_a), .blue_in(blue_a),
    .vga_r(vga_r_a), .vga_g(vga_g_a), .vga_b(vga_b_a),
    .hsync(hsync_a), .vsync(vsync_a), .blank_n(blank_n_a)
  );

  vga_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2), .CLK_DIV(1)) dut_b (
    .clk(clk), .reset(rst_b), .pix_en(pix_en_b), .hcount(hcount_b),
    .vcount(vcount_b), .active(active_b), .frame_start(fs_b),
    .red_in(red_b), .green_in(green_b), .blue_in(blue_b),
    .vga_r(vga_r_b), .vga_g(vga_g_b), .vga_b(vga_b_b),
    .hsync(hsync_b), .vsync(vsync_b), .blank_n(blank_n_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    int px_err, px_cnt, hs_first, hs_cur, hs_max, wrap1, wrap2, fs_cnt;
    int fs_first, fs_second, vs_cur, vs_max, vs_runs, vs_h, vs_v;
    int alias_cnt, blank_err, blank_cnt, act_err, prev_hc, prev_vc, p;
    logic [9:0] prev_h;
    logic exp_vis, exp_hs;

    rst_a = 1'b0;
    rst_b = 1'b0;
    rgb_mode = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);

    // Reset state with red_in forced to FF.
    check("rst_pix_en", 32'(pix_en_a), 0);
    check("rst_hcount", 32'(hcount_a), 0);
    check("rst_vcount", 32'(vcount_a), 0);
    check("rst_vga_r", 32'(vga_r_a), 0);
    check("rst_blank_n", 32'(blank_n_a), 0);
    check("rst_hsync", 32'(hsync_a), 1);
    check("rst_vsync", 32'(vsync_a), 1);
    check("rst_frame_start", 32'(fs_a), 0);
    check("rst_b_pix_en", 32'(pix_en_b), 0);

    // Release: strobe appears after the first clk and advances h at the second.
    rgb_mode = 1'b1;
    rst_a = 1'b1;
    @(negedge clk);
    check("first_strobe", 32'(pix_en_a), 1);
    check("first_strobe_h", 32'(hcount_a), 0);
    @(negedge clk);
    check("second_clk_pix_en", 32'(pix_en_a), 0);
    check("second_clk_h", 32'(hcount_a), 1);
    check("pixel0_blank_n", 32'(blank_n_a), 1);

    // Latency: pins show pixel h-1 while hcount shows h.
    for (int i = 0; i < 400 && hcount_a != 10'd101; i++) @(negedge clk);
    check("reach_h101", 32'(hcount_a), 101);
    check("lat_vga_r", 32'(vga_r_a), 100);
    check("lat_vga_g", 32'(vga_g_a), 32'hAA);
    check("lat_vga_b", 32'(vga_b_a), 32'h55);
    check("lat_blank_n", 32'(blank_n_a), 1);

    // Line scan over ~1700 pixels spanning two hcount wraps.
    px_err = 0; px_cnt = 0; hs_first = -1; hs_cur = 0; hs_max = 0;
    wrap1 = -1; wrap2 = -1; fs_cnt = 0;
    prev_h = hcount_a;
    for (int i = 1; i <= 3400; i++) begin
      @(negedge clk);
      if (fs_a === 1'b1) fs_cnt++;
      if (hcount_a != prev_h) begin
        px_cnt++;
        p = int'(prev_h);
        exp_vis = (p < 640);
        exp_hs  = !(p >= 656 && p < 752);
        if (blank_n_a !== exp_vis) px_err++;
        if (vga_g_a !== (exp_vis ? 8'hAA : 8'h00)) px_err++;
        if (vga_r_a !== (exp_vis ? p[7:0] : 8'h00)) px_err++;
        if (hsync_a !== exp_hs) px_err++;
        if (hsync_a === 1'b0) begin
          hs_cur++;
          if (hs_first < 0) hs_first = int'(hcount_a);
        end else begin
          if (hs_cur > hs_max) hs_max = hs_cur;
          hs_cur = 0;
        end
        if (prev_h == 10'd799 && hcount_a == 10'd0) begin
          if (wrap1 < 0) wrap1 = i;
          else if (wrap2 < 0) wrap2 = i;
        end
        prev_h = hcount_a;
      end
    end
    check("line_pixel_errors", 32'(px_err), 0);
    check("line_pixels_seen", 32'(px_cnt), 1700);
    check("hsync_first_h", 32'(hs_first), 657);
    check("hsync_width", 32'(hs_max), 96);
    check("line_period_clks", 32'(wrap2 - wrap1), 1600);
    check("line_vcount", 32'(vcount_a), 2);
    check("line_no_frame_start", 32'(fs_cnt), 0);

    // Frame scan on dut_b: two full frames of 12600 pixels.
    rst_b = 1'b1;
    fs_first = -1; fs_second = -1; fs_cnt = 0;
    vs_cur = 0; vs_max = 0; vs_runs = 0; vs_h = -1; vs_v = -1;
    alias_cnt = 0; blank_err = 0; blank_cnt = 0; act_err = 0;
    prev_hc = 0; prev_vc = 0;
    for (int i = 1; i <= 26000; i++) begin
      @(negedge clk);
      if (fs_b === 1'b1) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = i;
        else if (fs_second < 0) fs_second = i;
      end
      if (vsync_b === 1'b0) begin
        if (vs_cur == 0) begin
          vs_runs++;
          if (vs_h < 0) begin
            vs_h = int'(hcount_b);
            vs_v = int'(vcount_b);
          end
        end
        vs_cur++;
      end else begin
        if (vs_cur > vs_max) vs_max = vs_cur;
        vs_cur = 0;
      end
      if (prev_vc == 511 && vcount_b == 9'd0) alias_cnt++;
      if (i >= 2 && prev_vc >= 480 && prev_vc <= 511) begin
        blank_cnt++;
        if (blank_n_b !== 1'b0 || vga_g_b !== 8'h00) blank_err++;
      end
      if (vcount_b >= 9'd480 && active_b !== 1'b0) act_err++;
      prev_hc = int'(hcount_b);
      prev_vc = int'(vcount_b);
    end
    check("frame_first_start", 32'(fs_first), 12600);
    check("frame_period", 32'(fs_second - fs_first), 12600);
    check("frame_start_count", 32'(fs_cnt), 2);
    check("vsync_start_h", 32'(vs_h), 1);
    check("vsync_start_v", 32'(vs_v), 490);
    check("vsync_width", 32'(vs_max), 48);
    check("vsync_runs", 32'(vs_runs), 2);
    check("vcount_alias_511_0", 32'(alias_cnt), 2);
    check("vblank_pixels", 32'(blank_cnt), 1536);
    check("vblank_errors", 32'(blank_err), 0);
    check("vblank_active", 32'(act_err), 0);

    // Mid-frame reset of dut_b at (h=12, v=200).
    for (int i = 0; i < 6000 && !(hcount_b == 10'd12 && vcount_b == 9'd200); i++) @(negedge clk);
    check("reach_h12_v200", 32'({hcount_b, 7'd0, vcount_b}), 32'({10'd12, 7'd0, 9'd200}));
    check("pre_reset_vga_r", 32'(vga_r_b), 11);
    rst_b = 1'b0;
    #1;
    check("midrst_hcount", 32'(hcount_b), 0);
    check("midrst_vcount", 32'(vcount_b), 0);
    check("midrst_pix_en", 32'(pix_en_b), 0);
    check("midrst_vga_r", 32'(vga_r_b), 0);
    check("midrst_blank_n", 32'(blank_n_b), 0);
    check("midrst_syncs", 32'({hsync_b, vsync_b}), 3);
    repeat (3) @(negedge clk);
    check("midrst_hold_h", 32'(hcount_b), 0);
    rst_b = 1'b1;
    fs_cnt = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (fs_b === 1'b1) fs_cnt++;
      if (i == 1) check("restart_h0", 32'(hcount_b), 0);
      if (i == 2) check("restart_hv", 32'({hcount_b, vcount_b}), 32'({10'd1, 9'd0}));
      if (i == 3) check("restart_vga_r", 32'(vga_r_b), 1);
    end
    check("restart_no_frame_start", 32'(fs_cnt), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates 640x480@60 Hz VGA raster timing from the system clock. Drives the pixel coordinates consumed by the colour/map renderer. Takes back the renderer's combinational RGB and registers it, with HSYNC and VSYNC delayed so all three stay aligned at the DAC/connector pins. It is the source end of the Hcount/Vcount/RGB interface.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
CLK_DIV, 2, system clocks per pixel (>=1)
SYNC_POL, 0, sync asserted level (0 = active-low)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low
pix_en  out  1  one-clk pixel strobe
hcount  out  10  horizontal pixel counter
vcount  out  9  vertical line counter, low 9 bits
active  out  1  current pixel visible
frame_start  out  1  one-clk pulse at frame wrap
red_in  in  8  renderer red for (hcount,vcount)
green_in  in  8  renderer green
blue_in  in  8  renderer blue
vga_r  out  8  registered red
vga_g  out  8  registered green
vga_b  out  8  registered blue
hsync  out  1  horizontal sync, delayed to match RGB
vsync  out  1  vertical sync, delayed to match RGB
blank_n  out  1  high while registered RGB is visible

Behaviour:
- Reset is asynchronous and active-low; clock is clk. While reset=0: div, h and v counters = 0; pix_en = 0; frame_start = 0; vga_r/g/b = 0; blank_n = 0; hsync/vsync = deasserted (~SYNC_POL).
- Derived totals: H_TOTAL = sum of the H parameters (800). V_TOTAL = sum of the V parameters (525).
- Divider: div counts 0..CLK_DIV-1 and wraps. pix_en = 1 for the single clk where div == CLK_DIV-1. With CLK_DIV=1, pix_en is constantly 1 after reset.
- Horizontal counter h (10 bit): advances only on pix_en. Wraps H_TOTAL-1 -> 0.
- Vertical counter v (10 bit internal): advances on pix_en when h == H_TOTAL-1. Wraps V_TOTAL-1 -> 0.
- hcount = h.
- vcount = v[8:0], truncated. Lines 512..524 alias to 0..12, so consumers must qualify with active.
- active = (h < H_ACTIVE) && (v < V_ACTIVE). Combinational from the counters.
- frame_start = pix_en && h == H_TOTAL-1 && v == V_TOTAL-1. The next pixel is (0,0).
- Sync windows:
  - raw hs asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751).
  - raw vs asserted for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491).
  - Asserted level is SYNC_POL.
- Output stage: on each pix_en clk, register the following, and hold them between strobes:
  - vga_r/g/b <= active ? {red_in,green_in,blue_in} : 0
  - blank_n <= active
  - hsync <= raw hs; vsync <= raw vs
- Latency: RGB for coordinate (h,v) and its syncs appear on the pins exactly one pixel period after hcount/vcount present (h,v). red_in/green_in/blue_in must be combinational from hcount/vcount and settle within one system clk.
- Reset mid-line: all state returns to reset values immediately. The first pixel after release is (0,0) with no frame_start pulse.

Optional Feature:
VGA_TEST_PATTERN_EN
- Defined: adds input port test_en (1 bit). When test_en=1, the RGB registers sample an internal pattern instead of red_in/green_in/blue_in:
  - bar = hcount[9:6], giving ten 64-pixel bars.
  - each channel is 8'hFF or 0: r = bar[2], g = bar[1], b = bar[0].
  - blanking, latency and sync behave identically to normal mode.
- Undefined: no test_en port; RGB always comes from the inputs.

Test Plan:
- Reset: hold reset=0 for 10 clks, drive red_in=8'hFF. Required: vga_r=0, blank_n=0, hsync=vsync=1, pix_en=0, hcount=vcount=0. After release, first pix_en occurs at clk 2 (CLK_DIV=2).
- Line timing: CLK_DIV=2. Required: hsync low for 96 consecutive pixels starting at the pixel after h=656; period 1600 clks; hcount wraps 799 -> 0.
- Frame timing: Required: vsync low for exactly 2 lines (1600 pixels) starting one pixel after (h=0,v=490). frame_start pulses once every 420000 pixels (840000 clks). vcount shows 511 -> 0 aliasing at v=512.
- Latency/alignment: red_in = hcount[7:0]. Required: while hcount=101, vga_r=100, and blank_n=1 for active pixels 0..639.
- Blanking: green_in=8'hAA constant. Required: vga_g=0 and blank_n=0 for pixels with h=640..799 and for lines v>=480.
- Reset mid-frame at (h=300,v=200), held 3 clks: outputs return to reset values immediately, and the counters restart at (0,0) with no spurious frame_start.
